updown_counter_mod: RTL and testbench

- Parametrised loadable up/down counter with a runtime-programmable modulus, a terminal-count pulse and a one-shot/free-running mode.
- Generalises the 4-bit free-running load counter to any width.
- Adds direction control, count enable, synchronous clear, modulo wrap and a halt-on-terminal FSM.
- Used as a timebase, event counter and timeout generator by control blocks.

---
 rtl/updown_counter_pkg.sv | 14 +
 rtl/updown_counter_next.sv | 37 +++
 rtl/updown_counter_mod.sv | 98 +++++++++
 tb/tb_updown_counter_mod.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the up/down counter.
// The optional snapshot register is enabled by defining UPDOWN_COUNTER_SNAPSHOT_EN.
package updown_counter_pkg;

    // RUN advances the counter; HALT freezes it after a one-shot terminal event
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } cnt_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational step function: given the current count, direction and modulus,
// produce the wrapped next value and flag a terminal event.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] next_count,
    output logic             terminal
);

    // Up counts wrap to 0 once at or past mod_max; down counts wrap to mod_max from 0.
    // A value above mod_max (only reachable by load) still decrements normally.
    always_comb begin
        next_count = count;
        terminal   = 1'b0;
        if (up_dn == DIR_UP) begin
            if (count >= mod_max) begin
                terminal   = 1'b1;
                next_count = '0;
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                terminal   = 1'b1;
                next_count = mod_max;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Loadable up/down modulo counter with terminal-count pulse and one-shot halt.
// Define UPDOWN_COUNTER_SNAPSHOT_EN to add the capture input and snap output.
module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    ,
    input  logic             capture,
    output logic [WIDTH-1:0] snap
`endif
);

    cnt_state_t       state_q;
    cnt_state_t       state_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic [WIDTH-1:0] step_next;
    logic             step_terminal;

    updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (count),
        .up_dn      (up_dn),
        .mod_max    (mod_max),
        .next_count (step_next),
        .terminal   (step_terminal)
    );

    // Next-state logic: clear beats load beats an enabled step; HALT ignores stepping
    always_comb begin
        state_d = state_q;
        count_d = count;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = RESET_VAL;
            state_d = RUN;
        end else if (load) begin
            count_d = load_data;
            state_d = RUN;
        end else if (en && (state_q == RUN)) begin
            if (step_terminal) begin
                tc_d = 1'b1;
                if (one_shot) begin
                    // Park on the terminal value rather than the wrap value
                    count_d = (up_dn == DIR_UP) ? mod_max : '0;
                    state_d = HALT;
                end else begin
                    count_d = step_next;
                end
            end else begin
                count_d = step_next;
            end
        end
    end

    // State, count and terminal-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            count   <= RESET_VAL;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            tc      <= tc_d;
        end
    end

    assign done = (state_q == HALT);

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    // Snapshot of the pre-update count, independent of enable, FSM state and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (capture) begin
            snap <= count;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod with WIDTH=8, RESET_VAL=0.
// Define UPDOWN_COUNTER_SNAPSHOT_EN to also exercise the snapshot register.
module tb_updown_counter_mod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         clear;
    logic         load;
    logic [W-1:0] load_data;
    logic         up_dn;
    logic [W-1:0] mod_max;
    logic         one_shot;
    logic [W-1:0] count;
    logic         tc;
    logic         done;
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
    logic         capture;
    logic [W-1:0] snap;
`endif

    int tests = 0;
    int fails = 0;

    updown_counter_mod #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .load      (load),
        .load_data (load_data),
        .up_dn     (up_dn),
        .mod_max   (mod_max),
        .one_shot  (one_shot),
        .count     (count),
        .tc        (tc),
        .done      (done)
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
        ,
        .capture   (capture),
        .snap      (snap)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [W-1:0] c, input logic t, input logic d);
        check({tag, ".count"}, 16'(count), 16'(c));
        check({tag, ".tc"},    16'(tc),    16'(t));
        check({tag, ".done"},  16'(done),  16'(d));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; load_data = '0;
        up_dn = 1'b1; mod_max = 8'hFF; one_shot = 1'b0;
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
        capture = 1'b0;
`endif
        step();
        chk3("reset_init", 8'h00, 1'b0, 1'b0);
`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
        check("reset_snap", 16'(snap), 16'h0000);
`endif

        // Reset in the middle of a count
        reset = 1'b0; load = 1'b1; load_data = 8'h37;
        step();
        chk3("load_37", 8'h37, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; reset = 1'b1;
        step();
        chk3("reset_mid", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk3("resume1", 8'h01, 1'b0, 1'b0);
        step();
        chk3("resume2", 8'h02, 1'b0, 1'b0);

        // Free-running up, modulus 5
        clear = 1'b1; mod_max = 8'd5;
        step();
        chk3("up5_clear", 8'h00, 1'b0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk3($sformatf("up5_%0d", i), 8'((i + 1) % 6), ((i + 1) % 6) == 0, 1'b0);
        end

        // Down wrap, modulus 9
        mod_max = 8'd9; up_dn = 1'b0; load = 1'b1; load_data = 8'd2;
        step();
        chk3("dn9_load", 8'd2, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("dn9_a", 8'd1, 1'b0, 1'b0);
        step(); chk3("dn9_b", 8'd0, 1'b0, 1'b0);
        step(); chk3("dn9_wrap", 8'd9, 1'b1, 1'b0);
        step(); chk3("dn9_c", 8'd8, 1'b0, 1'b0);

        // One-shot up, modulus 3
        clear = 1'b1; up_dn = 1'b1; mod_max = 8'd3; one_shot = 1'b1;
        step(); chk3("os_clear", 8'd0, 1'b0, 1'b0);
        clear = 1'b0;
        step(); chk3("os_1", 8'd1, 1'b0, 1'b0);
        step(); chk3("os_2", 8'd2, 1'b0, 1'b0);
        step(); chk3("os_3", 8'd3, 1'b0, 1'b0);
        step(); chk3("os_term", 8'd3, 1'b1, 1'b1);
        step(); chk3("os_held", 8'd3, 1'b0, 1'b1);
        up_dn = 1'b0;
        step(); chk3("os_held_dn", 8'd3, 1'b0, 1'b1);
        up_dn = 1'b1; load = 1'b1; load_data = 8'd1;
        step(); chk3("os_reload", 8'd1, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("os_resume", 8'd2, 1'b0, 1'b0);
        one_shot = 1'b0;

        // Simultaneous controls and an out-of-range load
        clear = 1'b1; load = 1'b1; load_data = 8'h55;
        step(); chk3("clr_over_load", 8'h00, 1'b0, 1'b0);
        clear = 1'b0; load_data = 8'hFE; mod_max = 8'h10;
        step(); chk3("load_FE", 8'hFE, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("FE_wrap", 8'h00, 1'b1, 1'b0);

        // Zero modulus: every enabled step is terminal
        mod_max = 8'h00;
        step(); chk3("mod0_up_a", 8'h00, 1'b1, 1'b0);
        step(); chk3("mod0_up_b", 8'h00, 1'b1, 1'b0);
        up_dn = 1'b0;
        step(); chk3("mod0_dn", 8'h00, 1'b1, 1'b0);
        en = 1'b0;
        step(); chk3("mod0_en0", 8'h00, 1'b0, 1'b0);

        // Down count from above the modulus decrements normally
        en = 1'b1; mod_max = 8'd5; load = 1'b1; load_data = 8'h20;
        step(); chk3("above_load", 8'h20, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("above_dn", 8'h1F, 1'b0, 1'b0);

        // One-shot down halts at 0
        one_shot = 1'b1; mod_max = 8'd9; load = 1'b1; load_data = 8'd2;
        step(); chk3("osd_load", 8'd2, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("osd_1", 8'd1, 1'b0, 1'b0);
        step(); chk3("osd_0", 8'd0, 1'b0, 1'b0);
        step(); chk3("osd_term", 8'd0, 1'b1, 1'b1);
        clear = 1'b1;
        step(); chk3("osd_clear", 8'd0, 1'b0, 1'b0);
        clear = 1'b0; one_shot = 1'b0;

`ifdef UPDOWN_COUNTER_SNAPSHOT_EN
        // Snapshot captures the pre-update count and survives clear
        up_dn = 1'b1; mod_max = 8'hFF; load = 1'b1; load_data = 8'h21;
        step(); chk3("snap_load", 8'h21, 1'b0, 1'b0);
        load = 1'b0; capture = 1'b1;
        step();
        chk3("snap_step", 8'h22, 1'b0, 1'b0);
        check("snap_cap", 16'(snap), 16'h0021);
        capture = 1'b0; clear = 1'b1;
        step();
        chk3("snap_clear", 8'h00, 1'b0, 1'b0);
        check("snap_keep", 16'(snap), 16'h0021);
        clear = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
